// File: rtl/data_bus_arbiter_if.sv
// Bundle of the CPU, program-loader, data-BRAM and IO-bus signals around the data bus arbiter.
// The arbiter connects through "master"; the surrounding environment connects through "slave".
interface data_bus_arbiter_if #(
  parameter int DMEM_AW = 14
);
  logic               cpu_mem_read;
  logic               cpu_mem_write;
  logic               cpu_io_read;
  logic               cpu_io_write;
  logic               cpu_lb;
  logic               cpu_lbu;
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wdata;
  logic               cpu_stall;
  logic [31:0]        cpu_rdata;
  logic               cpu_err;

  logic               ldr_req;
  logic [DMEM_AW-1:0] ldr_addr;
  logic [31:0]        ldr_wdata;
  logic               ldr_gnt;

  logic               dmem_en;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;

  logic               io_req;
  logic               io_we;
  logic [9:0]         io_addr;
  logic [31:0]        io_wdata;
  logic [31:0]        io_rdata;
  logic               io_ack;

  modport master (
    input  cpu_mem_read, cpu_mem_write, cpu_io_read, cpu_io_write,
    input  cpu_lb, cpu_lbu, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_err,
    input  ldr_req, ldr_addr, ldr_wdata,
    output ldr_gnt,
    output dmem_en, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata,
    output io_req, io_we, io_addr, io_wdata,
    input  io_rdata, io_ack
  );

  modport slave (
    output cpu_mem_read, cpu_mem_write, cpu_io_read, cpu_io_write,
    output cpu_lb, cpu_lbu, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_err,
    output ldr_req, ldr_addr, ldr_wdata,
    input  ldr_gnt,
    input  dmem_en, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata,
    input  io_req, io_we, io_addr, io_wdata,
    output io_rdata, io_ack
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Sequences CPU data-side loads/stores and IO accesses, stalling the core while they are outstanding,
// and round-robins the data BRAM between the core and the UART program loader.
module data_bus_arbiter #(
  parameter int DMEM_AW    = 14,
  parameter int IO_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  data_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, MEM_RD, IO_WAIT, DONE} state_t;
  localparam int CW = $clog2(IO_TIMEOUT + 1);

  state_t        state, state_next;
  logic          last_ldr, last_ldr_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   rdata, rdata_next;
  logic          err, err_next;
  logic          io_req, io_req_next;
  logic          io_we, io_we_next;
  logic [9:0]    io_addr, io_addr_next;
  logic [31:0]   io_wdata, io_wdata_next;
  logic [1:0]    byte_sel, byte_sel_next;
  logic          mode_lb, mode_lb_next;
  logic          mode_lbu, mode_lbu_next;

  logic io_acc, mem_acc, ldr_win, cpu_win;
  logic unused_addr_bits;

  assign unused_addr_bits = ^bus.cpu_addr[31:DMEM_AW+2];

  // IO never competes with the loader; memory contention goes to whoever was not granted last.
  assign io_acc  = bus.cpu_io_read | bus.cpu_io_write;
  assign mem_acc = ~io_acc & (bus.cpu_mem_read | bus.cpu_mem_write);
  assign ldr_win = bus.ldr_req & (~mem_acc | ~last_ldr);
  assign cpu_win = mem_acc & ~ldr_win;

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] sel,
                                      input logic lb, input logic lbu);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    if (lb)       return {{24{b[7]}}, b};
    else if (lbu) return {24'b0, b};
    else          return w;
  endfunction

  always_comb begin
    state_next     = state;
    last_ldr_next  = last_ldr;
    cnt_next       = cnt;
    rdata_next     = rdata;
    err_next       = 1'b0;
    io_req_next    = io_req;
    io_we_next     = io_we;
    io_addr_next   = io_addr;
    io_wdata_next  = io_wdata;
    byte_sel_next  = byte_sel;
    mode_lb_next   = mode_lb;
    mode_lbu_next  = mode_lbu;
    bus.cpu_stall  = 1'b0;
    bus.ldr_gnt    = 1'b0;
    bus.dmem_en    = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;

    case (state)
      IDLE: begin
        bus.cpu_stall = io_acc | (mem_acc & (~bus.cpu_mem_write | ldr_win));
        if (ldr_win) begin
          bus.ldr_gnt    = 1'b1;
          bus.dmem_en    = 1'b1;
          bus.dmem_we    = 1'b1;
          bus.dmem_addr  = bus.ldr_addr;
          bus.dmem_wdata = bus.ldr_wdata;
          last_ldr_next  = 1'b1;
        end else if (cpu_win) begin
          bus.dmem_en    = 1'b1;
          bus.dmem_we    = bus.cpu_mem_write;
          bus.dmem_addr  = bus.cpu_addr[DMEM_AW+1:2];
          bus.dmem_wdata = bus.cpu_wdata;
          last_ldr_next  = 1'b0;
          if (!bus.cpu_mem_write) begin
            byte_sel_next = bus.cpu_addr[1:0];
            mode_lb_next  = bus.cpu_lb;
            mode_lbu_next = bus.cpu_lbu;
            state_next    = MEM_RD;
          end
        end
        if (io_acc) begin
          io_addr_next  = bus.cpu_addr[9:0];
          io_we_next    = bus.cpu_io_write;
          io_wdata_next = bus.cpu_wdata;
          byte_sel_next = bus.cpu_addr[1:0];
          mode_lb_next  = bus.cpu_lb;
          mode_lbu_next = bus.cpu_lbu;
          io_req_next   = 1'b1;
          cnt_next      = '0;
          state_next    = IO_WAIT;
        end
      end
      MEM_RD: begin
        bus.cpu_stall = 1'b1;
        rdata_next    = fmt(bus.dmem_rdata, byte_sel, mode_lb, mode_lbu);
        state_next    = DONE;
      end
      IO_WAIT: begin
        bus.cpu_stall = 1'b1;
        // An ack arriving on the last allowed cycle still completes normally.
        if (bus.io_ack) begin
          if (!io_we) rdata_next = fmt(bus.io_rdata, byte_sel, mode_lb, mode_lbu);
          io_req_next = 1'b0;
          state_next  = DONE;
        end else if (cnt == CW'(IO_TIMEOUT - 1)) begin
          io_req_next = 1'b0;
          rdata_next  = '0;
          err_next    = 1'b1;
          state_next  = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_ldr <= 1'b0;
      cnt      <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= '0;
      io_wdata <= '0;
      byte_sel <= '0;
      mode_lb  <= 1'b0;
      mode_lbu <= 1'b0;
    end else begin
      state    <= state_next;
      last_ldr <= last_ldr_next;
      cnt      <= cnt_next;
      rdata    <= rdata_next;
      err      <= err_next;
      io_req   <= io_req_next;
      io_we    <= io_we_next;
      io_addr  <= io_addr_next;
      io_wdata <= io_wdata_next;
      byte_sel <= byte_sel_next;
      mode_lb  <= mode_lb_next;
      mode_lbu <= mode_lbu_next;
    end
  end

  assign bus.cpu_rdata = rdata;
  assign bus.cpu_err   = err;
  assign bus.io_req    = io_req;
  assign bus.io_we     = io_we;
  assign bus.io_addr   = io_addr;
  assign bus.io_wdata  = io_wdata;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: BRAM and IO responder models around the DUT, with a
// scoreboard of expected per-access results popped when the core is released.
module tb_data_bus_arbiter;
  localparam int AW = 14;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          chk_rdata;
    int          stalls;
    int          ioreqs;
    int          gnts;
    int          errs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic          first_en, first_we;
  logic [AW-1:0] first_addr;

  data_bus_arbiter_if #(.DMEM_AW(AW)) bus ();

  data_bus_arbiter #(.DMEM_AW(AW), .IO_TIMEOUT(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] dmem_rd;
  always @(posedge clk) begin
    if (bus.dmem_en) begin
      if (bus.dmem_we) mem[bus.dmem_addr] <= bus.dmem_wdata;
      else             dmem_rd <= mem[bus.dmem_addr];
    end
  end
  assign bus.dmem_rdata = dmem_rd;

  // IO responder: acks on the ack_at-th cycle of io_req (0 = never)
  int          ack_at = 0;
  logic [31:0] io_val = '0;
  int          io_hi;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) io_hi <= 0;
    else        io_hi <= bus.io_req ? io_hi + 1 : 0;
  end
  assign bus.io_ack   = bus.io_req && (ack_at != 0) && (io_hi == ack_at - 1);
  assign bus.io_rdata = bus.io_ack ? io_val : 32'h0;

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [3:0] fl, input logic lb, input logic lbu,
                           input logic [31:0] addr, input logic [31:0] wdata);
    {bus.cpu_io_read, bus.cpu_io_write, bus.cpu_mem_read, bus.cpu_mem_write} = fl;
    bus.cpu_lb    = lb;
    bus.cpu_lbu   = lbu;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  // fl = {io_read, io_write, mem_read, mem_write}; entered and left just after a rising edge
  task automatic run_access(input string tag, input logic [3:0] fl, input logic lb, input logic lbu,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input bit chk, input logic [31:0] erd,
                            input int est, input int eio, input int egn, input int eer);
    exp_t        e;
    exp_t        got;
    int          stalls = 0, ioreqs = 0, gnts = 0, errs = 0;
    bit          done = 0;
    logic [31:0] rd_seen = '0;
    e = '{tag, erd, chk, est, eio, egn, eer};
    sb.push_back(e);
    set_flags(fl, lb, lbu, addr, wdata);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        first_en   = bus.dmem_en;
        first_we   = bus.dmem_we;
        first_addr = bus.dmem_addr;
      end
      gnts   += int'(bus.ldr_gnt);
      ioreqs += int'(bus.io_req);
      errs   += int'(bus.cpu_err);
      if (!bus.cpu_stall) begin
        done    = 1;
        rd_seen = bus.cpu_rdata;
      end else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    check(tag, "released", 32'(done), 32'd1);
    @(posedge clk); #1;
    set_flags(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    gnts += int'(bus.ldr_gnt);
    errs += int'(bus.cpu_err);
    got = sb.pop_front();
    if (got.chk_rdata) check(got.tag, "rdata", rd_seen, got.rdata);
    check(got.tag, "stalls", 32'(stalls), 32'(got.stalls));
    check(got.tag, "io_req_cycles", 32'(ioreqs), 32'(got.ioreqs));
    check(got.tag, "ldr_gnts", 32'(gnts), 32'(got.gnts));
    check(got.tag, "err_pulses", 32'(errs), 32'(got.errs));
    $display("txn %s stalls=%0d io_req=%0d gnts=%0d errs=%0d rdata=0x%08h", tag, stalls, ioreqs, gnts, errs, rd_seen);
    @(posedge clk); #1;
  endtask

  initial begin
    set_flags(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.ldr_req   = 1'b0;
    bus.ldr_addr  = '0;
    bus.ldr_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset", "cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("reset", "cpu_rdata", bus.cpu_rdata, 32'h0);
    check("reset", "cpu_err", 32'(bus.cpu_err), 32'd0);
    check("reset", "io_req", 32'(bus.io_req), 32'd0);
    check("reset", "dmem_en", 32'(bus.dmem_en), 32'd0);
    check("reset", "ldr_gnt", 32'(bus.ldr_gnt), 32'd0);
    $display("txn reset done");
    @(posedge clk); #1;

    // loader burst, one word per cycle while the CPU is idle
    bus.ldr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ldr_addr  = AW'(4 + i);
      bus.ldr_wdata = (i == 0) ? 32'hDEADBEEF : 32'h11110000 + 32'(4 + i);
      @(negedge clk);
      check("ldr_burst", "gnt", 32'(bus.ldr_gnt), 32'd1);
      check("ldr_burst", "dmem_addr", 32'(bus.dmem_addr), 32'(4 + i));
      $display("txn ldr_burst word=%0d gnt=%0b", 4 + i, bus.ldr_gnt);
      @(posedge clk); #1;
    end
    bus.ldr_req = 1'b0;
    check("ldr_burst", "mem4", mem[4], 32'hDEADBEEF);

    run_access("word_load", 4'b0010, 0, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 2, 0, 0, 0);
    check("word_load", "first_en", 32'(first_en), 32'd1);
    check("word_load", "first_we", 32'(first_we), 32'd0);
    check("word_load", "dmem_addr", 32'(first_addr), 32'd4);

    bus.ldr_req = 1'b1; bus.ldr_addr = AW'(4); bus.ldr_wdata = 32'h80FF0000;
    @(negedge clk);
    check("ldr_single", "gnt", 32'(bus.ldr_gnt), 32'd1);
    @(posedge clk); #1;
    bus.ldr_req = 1'b0;

    run_access("lb_13",  4'b0010, 1, 0, 32'h13, 32'h0, 1, 32'hFFFFFF80, 2, 0, 0, 0);
    run_access("lbu_13", 4'b0010, 0, 1, 32'h13, 32'h0, 1, 32'h00000080, 2, 0, 0, 0);
    run_access("lb_12",  4'b0010, 1, 0, 32'h12, 32'h0, 1, 32'hFFFFFFFF, 2, 0, 0, 0);

    run_access("store", 4'b0001, 0, 0, 32'h20, 32'h12345678, 0, 32'h0, 0, 0, 0, 0);
    check("store", "first_we", 32'(first_we), 32'd1);
    check("store", "dmem_addr", 32'(first_addr), 32'd8);
    check("store", "mem8", mem[8], 32'h12345678);

    ack_at = 3; io_val = 32'h5A;
    run_access("io_read", 4'b1000, 0, 0, 32'hFFFFFC40, 32'h0, 1, 32'h5A, 4, 3, 0, 0);
    check("io_read", "io_addr", 32'(bus.io_addr), 32'h040);
    check("io_read", "io_we", 32'(bus.io_we), 32'd0);

    ack_at = 0;
    run_access("io_timeout", 4'b0100, 0, 0, 32'hFFFFFC44, 32'hCAFE0001, 1, 32'h0, 16, 15, 0, 1);
    check("io_timeout", "io_we", 32'(bus.io_we), 32'd1);
    check("io_timeout", "io_wdata", bus.io_wdata, 32'hCAFE0001);

    ack_at = 15; io_val = 32'h77;
    run_access("io_ack_last", 4'b1000, 0, 0, 32'hFFFFFC48, 32'h0, 1, 32'h77, 16, 15, 0, 0);

    // loader wins first (last_ldr=0), CPU load next, loader regranted after DONE
    ack_at = 0;
    bus.ldr_req = 1'b1; bus.ldr_addr = AW'(200); bus.ldr_wdata = 32'hA5A5A5A5;
    run_access("contend_load", 4'b0010, 0, 0, 32'h10, 32'h0, 1, 32'h80FF0000, 3, 0, 2, 0);
    bus.ldr_req = 1'b0;
    check("contend_load", "mem200", mem[200], 32'hA5A5A5A5);

    run_access("store2", 4'b0001, 0, 0, 32'h24, 32'h0BADF00D, 0, 32'h0, 0, 0, 0, 0);
    bus.ldr_req = 1'b1; bus.ldr_addr = AW'(300); bus.ldr_wdata = 32'h3000_0300;
    run_access("contend_store", 4'b0001, 0, 0, 32'h28, 32'h2800_0028, 0, 32'h0, 1, 0, 2, 0);
    bus.ldr_req = 1'b0;
    check("contend_store", "mem10", mem[10], 32'h2800_0028);
    check("contend_store", "mem300", mem[300], 32'h3000_0300);
    check("store2", "mem9", mem[9], 32'h0BADF00D);

    // reset dropped mid IO_WAIT, core held in reset alongside
    set_flags(4'b1000, 0, 0, 32'hFFFFFC50, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    check("rst_mid_io", "io_req_before", 32'(bus.io_req), 32'd1);
    rst_n = 1'b0;
    set_flags(4'b0000, 0, 0, 32'h0, 32'h0);
    #1;
    check("rst_mid_io", "io_req", 32'(bus.io_req), 32'd0);
    check("rst_mid_io", "cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("rst_mid_io", "cpu_rdata", bus.cpu_rdata, 32'h0);
    $display("txn rst_mid_io io_req=%0b stall=%0b", bus.io_req, bus.cpu_stall);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_access("post_reset_load", 4'b0010, 0, 0, 32'h14, 32'h0, 1, 32'h11110005, 2, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
